// File: rtl/wb_copy_pkg.sv
// wb_copy_pkg: shared FSM encoding and chunk sizing for the Wishbone copy master
package wb_copy_pkg;
  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, WR_WAIT, DONE} state_e;
  function automatic int unsigned chunk_len(input int unsigned rem, input int unsigned depth);
    return rem < depth ? rem : depth;
  endfunction
endpackage

// File: rtl/if_wb.sv
// if_wb: classic-pipelined Wishbone bus bundle
// master drives cyc/stb/we/adr/dat_m; slave drives dat_s/ack/stall
interface if_wb #(parameter int AW = 16, parameter int DW = 16);
  logic cyc;
  logic stb;
  logic we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_m;
  logic [DW-1:0] dat_s;
  logic ack;
  logic stall;
  modport master (output cyc, stb, we, adr, dat_m, input dat_s, ack, stall);
  modport slave (input cyc, stb, we, adr, dat_m, output dat_s, ack, stall);
endinterface

// File: rtl/wb_copy_master_fifo.sv
// sync_fifo: DEPTH x DW show-ahead FIFO holding one chunk of read data
// ports: clk, rst (async, active-high), push_i/din_i, pop_i/dout_o (head), empty_o, full_o
module sync_fifo #(parameter int DEPTH = 8, parameter int DW = 16) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic          empty_o,
  output logic          full_o
);
  localparam int PW = $clog2(DEPTH);
  logic [DW-1:0] mem_q [DEPTH];
  logic [PW:0] wp_q, rp_q;
  assign empty_o = wp_q == rp_q;
  assign full_o = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
  assign dout_o = mem_q[rp_q[PW-1:0]];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_q + (PW+1)'(push_i);
      rp_q <= rp_q + (PW+1)'(pop_i);
    end
  end
  always_ff @(posedge clk) if (push_i) mem_q[wp_q[PW-1:0]] <= din_i;
endmodule

// File: rtl/wb_copy_master.sv
// wb_copy_master: chunked Wishbone block-copy DMA (read up to DEPTH words, write them, repeat)
// ports: clk, rst (async, active-high), start pulse, src_adr/dst_adr/len,
//        busy, done pulse, wb (if_wb.master pipelined bus)
module wb_copy_master
  import wb_copy_pkg::*;
#(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src_adr,
  input  logic [AW-1:0] dst_adr,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  if_wb.master          wb
);
  localparam int CW = $clog2(DEPTH + 1);
  state_e state_q, state_d;
  logic [AW-1:0] rs_q, rs_d, rd_q, rd_d, rem_q, rem_d;
  logic [CW-1:0] iss_q, iss_d, ack_q, ack_d, chunk;
  logic acc, ackv, drain, push, pop, empty, full;
  logic [DW-1:0] head;
  assign chunk = CW'(chunk_len(32'(rem_q), DEPTH));
  // once every ack of the phase is in, cyc is released for exactly one cycle
  assign drain = (state_q == RD_WAIT || state_q == WR_WAIT) && ack_q == chunk;
  assign wb.cyc = (state_q == RD || state_q == RD_WAIT || state_q == WR || state_q == WR_WAIT) && !drain;
  assign wb.stb = state_q == RD || state_q == WR;
  assign wb.we = state_q == WR;
  assign wb.adr = state_q == RD ? rs_q : state_q == WR ? rd_q : '0;
  assign wb.dat_m = state_q == WR && !empty ? head : '0;
  assign acc = wb.cyc && wb.stb && !wb.stall;
  assign ackv = wb.cyc && wb.ack;
  assign push = ackv && (state_q == RD || state_q == RD_WAIT) && !full;
  assign pop = acc && state_q == WR;
  assign busy = state_q != IDLE && state_q != DONE;
  assign done = state_q == DONE;
  sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .clk(clk), .rst(rst), .push_i(push), .din_i(wb.dat_s), .pop_i(pop),
    .dout_o(head), .empty_o(empty), .full_o(full)
  );
  always_comb begin
    state_d = state_q;
    rs_d = rs_q + AW'(acc && state_q == RD);
    rd_d = rd_q + AW'(pop);
    rem_d = rem_q;
    iss_d = iss_q + CW'(acc);
    ack_d = ack_q + CW'(ackv);
    case (state_q)
      IDLE: if (start) begin
        rs_d = src_adr;
        rd_d = dst_adr;
        rem_d = len;
        state_d = len != '0 ? RD : DONE;
      end
      RD: if (iss_d == chunk) state_d = RD_WAIT;
      RD_WAIT: if (drain) begin
        iss_d = '0;
        ack_d = '0;
        state_d = WR;
      end
      WR: if (iss_d == chunk) state_d = WR_WAIT;
      WR_WAIT: if (drain) begin
        iss_d = '0;
        ack_d = '0;
        rem_d = rem_q - AW'(chunk);
        state_d = rem_q == AW'(chunk) ? DONE : RD;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rs_q <= '0;
      rd_q <= '0;
      rem_q <= '0;
      iss_q <= '0;
      ack_q <= '0;
    end else begin
      state_q <= state_d;
      rs_q <= rs_d;
      rd_q <= rd_d;
      rem_q <= rem_d;
      iss_q <= iss_d;
      ack_q <= ack_d;
    end
  end
endmodule

// File: tb/tb_wb_copy_master.sv
// tb_wb_copy_master: scoreboard bench with a pipelined RAM slave model (optional random stall / 1-3 cycle ack)
module tb_wb_copy_master;
  typedef struct {logic we; logic [15:0] adr; logic [15:0] dat;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [15:0] src_adr = '0, dst_adr = '0, len = '0;
  logic busy, done;
  logic ack_r = 1'b0, stall_r = 1'b0;
  logic [15:0] dat_r = '0;
  logic [15:0] mem [65536];
  exp_t exp_q[$];
  exp_t e_m;
  logic [15:0] gold_adr[$], gold_dat[$];
  logic [15:0] sq_dat[$];
  int sq_cnt[$];
  int n_chk = 0, n_fail = 0;
  int done_cnt = 0, busy_cnt = 0, rd_cnt = 0, wr_cnt = 0, rise_cnt = 0;
  int b_done, b_busy, b_rd, b_wr, b_rise;
  bit rnd = 1'b0, cyc_prev = 1'b0, hold_v = 1'b0;
  logic [15:0] h_adr, h_dat;
  logic h_we;

  if_wb #(.AW(16), .DW(16)) wb();
  assign wb.ack = ack_r;
  assign wb.stall = stall_r;
  assign wb.dat_s = dat_r;

  wb_copy_master #(.AW(16), .DW(16), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .src_adr(src_adr), .dst_adr(dst_adr),
    .len(len), .busy(busy), .done(done), .wb(wb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
    #1;
  endtask

  // slave model + bus monitor: decides ack/stall for the coming posedge and
  // scores every request that will be accepted on it
  always @(negedge clk) begin
    if (rst) begin
      sq_dat.delete();
      sq_cnt.delete();
      ack_r = 1'b0;
      stall_r = 1'b0;
      hold_v = 1'b0;
      cyc_prev = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_stb", wb.stb, 1);
        chk("hold_adr", wb.adr, h_adr);
        chk("hold_we", wb.we, h_we);
        chk("hold_dat", wb.dat_m, h_dat);
      end
      foreach (sq_cnt[i]) if (sq_cnt[i] > 0) sq_cnt[i]--;
      ack_r = 1'b0;
      if (sq_cnt.size() > 0 && sq_cnt[0] == 0) begin
        ack_r = 1'b1;
        dat_r = sq_dat.pop_front();
        void'(sq_cnt.pop_front());
        chk("ack_cyc", wb.cyc, 1);
      end
      stall_r = rnd && $urandom_range(0, 2) == 0;
      if (wb.cyc && wb.stb && !stall_r) begin
        chk("exp_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e_m = exp_q.pop_front();
          chk("acc_we", wb.we, e_m.we);
          chk("acc_adr", wb.adr, e_m.adr);
          if (e_m.we) chk("acc_dat", wb.dat_m, e_m.dat);
        end
        if (wb.we) begin
          mem[wb.adr] = wb.dat_m;
          wr_cnt++;
          sq_dat.push_back(16'h0);
        end else begin
          sq_dat.push_back(mem[wb.adr]);
          rd_cnt++;
        end
        sq_cnt.push_back(rnd ? int'($urandom_range(1, 3)) : 1);
        chk("outstanding", sq_cnt.size() <= 8, 1);
      end
      hold_v = wb.cyc && wb.stb && stall_r;
      h_adr = wb.adr;
      h_we = wb.we;
      h_dat = wb.dat_m;
      if (done) begin
        done_cnt++;
        chk("done_drain", exp_q.size() + sq_cnt.size(), 0);
        chk("done_busy", busy, 0);
      end
      if (busy) busy_cnt++;
      if (wb.cyc && !cyc_prev) rise_cnt++;
      cyc_prev = wb.cyc;
    end
  end

  task automatic start_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n, input bit r);
    logic [15:0] a;
    int c;
    rnd = r;
    gold_adr.delete();
    gold_dat.delete();
    for (int b = 0; b < int'(n); b += 8) begin
      c = (int'(n) - b < 8) ? int'(n) - b : 8;
      for (int i = 0; i < c; i++) exp_q.push_back('{1'b0, s + 16'(b + i), 16'h0});
      for (int i = 0; i < c; i++) begin
        a = s + 16'(b + i);
        exp_q.push_back('{1'b1, d + 16'(b + i), mem[a]});
        gold_adr.push_back(d + 16'(b + i));
        gold_dat.push_back(mem[a]);
      end
    end
    b_done = done_cnt;
    b_busy = busy_cnt;
    b_rd = rd_cnt;
    b_wr = wr_cnt;
    b_rise = rise_cnt;
    src_adr = s;
    dst_adr = d;
    len = n;
    start = 1'b1;
    nclk();
    start = 1'b0;
    if (n == 0) chk("done_next", done, 1);
    else chk("busy_next", busy, 1);
  endtask

  task automatic do_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n, input bit r, input bit dup);
    int t = 0;
    start_copy(s, d, n, r);
    if (dup) begin
      nclk();
      nclk();
      src_adr = 16'h1234;
      len = 16'd7;
      start = 1'b1;
      nclk();
      start = 1'b0;
    end
    while (done_cnt == b_done && t < 3000) begin
      nclk();
      t++;
    end
    chk("done_seen", done_cnt > b_done, 1);
    repeat (3) nclk();
    chk("done_once", done_cnt - b_done, 1);
    chk("busy_after", busy, 0);
    chk("rd_acc", rd_cnt - b_rd, n);
    chk("wr_acc", wr_cnt - b_wr, n);
    chk("cyc_rises", rise_cnt - b_rise, 2 * ((n + 7) / 8));
    chk("busy_seen", busy_cnt > b_busy, n != 0);
    foreach (gold_adr[i]) chk("dst_data", mem[gold_adr[i]], gold_dat[i]);
  endtask

  initial begin
    int t;
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 7) ^ 16'h5a5a;
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cyc", wb.cyc, 0);
    chk("rst_stb", wb.stb, 0);
    chk("rst_we", wb.we, 0);
    chk("rst_adr", wb.adr, 0);
    chk("rst_dat", wb.dat_m, 0);
    nclk();
    nclk();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) mem[i] = 16'hA0 + 16'(i);
    do_copy(16'h0000, 16'h0100, 16'd5, 1'b0, 1'b0);
    do_copy(16'h0300, 16'h0400, 16'd20, 1'b0, 1'b0);
    do_copy(16'h0000, 16'h0500, 16'd0, 1'b0, 1'b0);
    do_copy(16'h0600, 16'h0700, 16'd13, 1'b1, 1'b0);
    start_copy(16'h0800, 16'h0900, 16'd8, 1'b0);
    t = 0;
    while (wr_cnt - b_wr < 3 && t < 500) begin
      nclk();
      t++;
    end
    chk("rst_reach", t < 500, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_cyc", wb.cyc, 0);
    chk("abort_stb", wb.stb, 0);
    chk("abort_busy", busy, 0);
    nclk();
    nclk();
    rst = 1'b0;
    exp_q.delete();
    repeat (4) nclk();
    chk("abort_nodone", done_cnt - b_done, 0);
    do_copy(16'h0A00, 16'h0B00, 16'd2, 1'b0, 1'b0);
    do_copy(16'hFFFE, 16'h0200, 16'd4, 1'b0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
